// File: rtl/load_store_unit.sv
// Byte/halfword load-store unit in front of a single-cycle combinational data memory.
// Byte stores use read-modify-write; misaligned halfwords complete with an error and no memory access.
module load_store_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic                  req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  typedef enum logic [2:0] {IDLE, LOAD, RMW_READ, WRITE, RESP} state_t;

  state_t                  state, state_next;
  logic                    we_q, size_q, uns_q, err_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    accept;
  logic [ADDR_WIDTH-1:0]   word_addr;
  logic [7:0]              sel_byte;
  logic [DATA_WIDTH-1:0]   load_word;
  logic [DATA_WIDTH-1:0]   merged_word;

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign word_addr = {1'b0, addr_q[ADDR_WIDTH-1:1]};

  always_comb begin
    sel_byte = addr_q[0] ? mem_q[15:8] : mem_q[7:0];
    if (size_q)
      load_word = mem_q;
    else if (uns_q)
      load_word = {{(DATA_WIDTH-8){1'b0}}, sel_byte};
    else
      load_word = {{(DATA_WIDTH-8){sel_byte[7]}}, sel_byte};
    // data_q still holds the latched store data while in RMW_READ
    merged_word = mem_q;
    if (addr_q[0])
      merged_word[15:8] = data_q[7:0];
    else
      merged_word[7:0] = data_q[7:0];
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (req_size && req_addr[0]) state_next = RESP;
          else if (!req_we)            state_next = LOAD;
          else if (req_size)           state_next = WRITE;
          else                         state_next = RMW_READ;
        end
      end
      LOAD:     state_next = RESP;
      RMW_READ: state_next = WRITE;
      WRITE:    state_next = RESP;
      RESP:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_addr   = '0;
    mem_data   = '0;
    mem_we     = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    if (state == LOAD || state == RMW_READ || state == WRITE)
      mem_addr = word_addr;
    if (state == WRITE) begin
      mem_we   = 1'b1;
      mem_data = data_q;
    end
    if (state == RESP) begin
      resp_valid = 1'b1;
      resp_err   = err_q;
      if (!we_q && !err_q)
        resp_rdata = data_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      we_q   <= 1'b0;
      size_q <= 1'b0;
      uns_q  <= 1'b0;
      err_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state <= state_next;
      unique case (state)
        IDLE: begin
          if (accept) begin
            we_q   <= req_we;
            size_q <= req_size;
            uns_q  <= req_unsigned;
            err_q  <= req_size & req_addr[0];
            addr_q <= req_addr;
            data_q <= req_wdata;
          end
        end
        LOAD:     data_q <= load_word;
        RMW_READ: data_q <= merged_word;
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: timeline/reference-memory model checked every cycle, plus directed literal checks.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic        req_size = 1'b0;
  logic        req_unsigned = 1'b0;
  logic [15:0] req_addr = 16'h0;
  logic [15:0] req_wdata = 16'h0;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        resp_err;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_we;
  logic [15:0] mem_q;

  int errors = 0;
  int checks = 0;

  load_store_unit #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_we(mem_we), .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  // Data memory seen by the DUT (low 8 bits of the word address)
  logic [15:0] mem [256] = '{default: 16'h0};
  assign mem_q = mem[mem_addr[7:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:0]] <= mem_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] extract(input logic [15:0] w, input logic a0,
                                          input logic sz, input logic un);
    logic [7:0] b;
    b = a0 ? w[15:8] : w[7:0];
    if (sz) return w;
    if (un) return {8'h00, b};
    return {{8{b[7]}}, b};
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] w, input logic a0, input logic [15:0] wd);
    return a0 ? {wd[7:0], w[7:0]} : {w[15:8], wd[7:0]};
  endfunction

  // Reference model: phase counts cycles since accept; 0 means idle.
  logic [15:0] ref_mem [256] = '{default: 16'h0};
  int          phase = 0;
  int          m_lat = 0;
  logic        m_we = 1'b0, m_err = 1'b0;
  logic [15:0] m_waddr = 16'h0, m_word = 16'h0, m_rdata = 16'h0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= 0;
    end else if (phase == 0) begin
      if (req_valid) begin
        m_err   <= req_size & req_addr[0];
        m_we    <= req_we;
        m_waddr <= {1'b0, req_addr[15:1]};
        m_lat   <= (req_size & req_addr[0]) ? 1 : (req_we & ~req_size) ? 3 : 2;
        m_rdata <= (req_we | (req_size & req_addr[0])) ? 16'h0 :
                   extract(ref_mem[req_addr[8:1]], req_addr[0], req_size, req_unsigned);
        m_word  <= req_size ? req_wdata : merge(ref_mem[req_addr[8:1]], req_addr[0], req_wdata);
        phase   <= 1;
      end
    end else if (phase == m_lat) begin
      phase <= 0;
    end else begin
      if (m_we && !m_err && phase == m_lat - 1) ref_mem[m_waddr[7:0]] <= m_word;
      phase <= phase + 1;
    end
  end

  logic        in_flight, exp_resp, exp_we, exp_ready;
  logic [15:0] exp_addr, exp_data;
  assign in_flight = (phase != 0);
  assign exp_resp  = in_flight && phase == m_lat;
  assign exp_we    = in_flight && m_we && !m_err && phase == m_lat - 1;
  assign exp_addr  = (in_flight && !m_err && phase < m_lat) ? m_waddr : 16'h0;
  assign exp_data  = exp_we ? m_word : 16'h0;
  assign exp_ready = !rst && !in_flight;

  always @(negedge clk) begin
    check("req_ready", req_ready, exp_ready);
    check("resp_valid", resp_valid, exp_resp);
    check("mem_we", mem_we, exp_we);
    check("mem_addr", mem_addr, exp_addr);
    check("mem_data", mem_data, exp_data);
    if (exp_resp) begin
      check("resp_err", resp_err, m_err);
      check("resp_rdata", resp_rdata, m_rdata);
    end
  end

  task automatic issue(input logic we, input logic sz, input logic un,
                       input logic [15:0] addr, input logic [15:0] wd,
                       output logic [15:0] rd, output logic er, output int lat);
    req_we = we; req_size = sz; req_unsigned = un; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    rd = 16'h0; er = 1'b0; lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    @(posedge clk);
    #2 req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        rd = resp_rdata; er = resp_err; lat = k;
        break;
      end
    end
  endtask

  logic [15:0] rd;
  logic        er;
  int          lat;
  logic        rdy_s [6];
  logic        rv_s [6];
  logic [15:0] rdat_s [6];

  initial begin
    repeat (3) @(posedge clk);
    #2;
    check("rst_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    rst = 1'b0;

    issue(1'b1, 1'b1, 1'b0, 16'h0010, 16'hBEEF, rd, er, lat);
    check("hw_store_lat", lat, 2);
    check("hw_store_err", er, 0);
    check("mem8_beef", mem[8], 16'hBEEF);
    issue(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, rd, er, lat);
    check("hw_load_data", rd, 16'hBEEF);
    check("hw_load_lat", lat, 2);

    issue(1'b1, 1'b0, 1'b0, 16'h0011, 16'h0012, rd, er, lat);
    check("byte_store_lat", lat, 3);
    check("mem8_12ef", mem[8], 16'h12EF);
    issue(1'b1, 1'b0, 1'b0, 16'h0011, 16'hAB80, rd, er, lat);
    check("mem8_80ef", mem[8], 16'h80EF);

    issue(1'b0, 1'b0, 1'b0, 16'h0011, 16'h0000, rd, er, lat);
    check("byte_load_signed_hi", rd, 16'hFF80);
    issue(1'b0, 1'b0, 1'b1, 16'h0011, 16'h0000, rd, er, lat);
    check("byte_load_unsigned_hi", rd, 16'h0080);
    issue(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, rd, er, lat);
    check("byte_load_signed_lo", rd, 16'hFFEF);
    issue(1'b0, 1'b0, 1'b1, 16'h0010, 16'h0000, rd, er, lat);
    check("byte_load_unsigned_lo", rd, 16'h00EF);

    issue(1'b0, 1'b1, 1'b0, 16'h0003, 16'h0000, rd, er, lat);
    check("misaligned_load_err", er, 1);
    check("misaligned_load_lat", lat, 1);
    check("misaligned_load_data", rd, 16'h0000);
    issue(1'b1, 1'b1, 1'b0, 16'h0005, 16'hAAAA, rd, er, lat);
    check("misaligned_store_err", er, 1);
    check("misaligned_store_nowrite", mem[2], 16'h0000);

    issue(1'b1, 1'b0, 1'b0, 16'h0010, 16'h7734, rd, er, lat);
    check("mem8_8034", mem[8], 16'h8034);

    // Address wrap at the top of the byte space
    issue(1'b1, 1'b1, 1'b0, 16'hFFFE, 16'h1234, rd, er, lat);
    check("wrap_store_mem", mem[8'hFF], 16'h1234);
    issue(1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h0000, rd, er, lat);
    check("wrap_byte_load_hi", rd, 16'h0012);
    issue(1'b0, 1'b0, 1'b0, 16'hFFFE, 16'h0000, rd, er, lat);
    check("wrap_byte_load_lo", rd, 16'h0034);

    // Two queued loads with req_valid held high
    req_we = 1'b0; req_size = 1'b1; req_unsigned = 1'b0; req_addr = 16'h0010;
    req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      rdy_s[i] = req_ready; rv_s[i] = resp_valid; rdat_s[i] = resp_rdata;
      if (i == 1) req_addr = 16'hFFFE;
      if (i == 5) req_valid = 1'b0;
    end
    check("b2b_ready", {rdy_s[0], rdy_s[1], rdy_s[2], rdy_s[3], rdy_s[4], rdy_s[5]}, 6'b100100);
    check("b2b_resp", {rv_s[0], rv_s[1], rv_s[2], rv_s[3], rv_s[4], rv_s[5]}, 6'b001001);
    check("b2b_data1", rdat_s[2], 16'h8034);
    check("b2b_data2", rdat_s[5], 16'h1234);

    // Reset during the WRITE of a byte store
    req_we = 1'b1; req_size = 1'b0; req_addr = 16'h0010; req_wdata = 16'h0055;
    req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    @(posedge clk);
    #2 req_valid = 1'b0;
    @(posedge clk);
    #2 check("write_we_before_rst", mem_we, 1);
    rst = 1'b1;
    #1 check("rst_drops_we", mem_we, 0);
    check("rst_drops_ready", req_ready, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", req_ready, 1);
    check("rst_no_write", mem[8], 16'h8034);
    issue(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, rd, er, lat);
    check("load_after_rst", rd, 16'h8034);
    check("load_after_rst_lat", lat, 2);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the memory word and request data width.
REQ-002 Parameter ADDR_WIDTH, default 16, SHALL set the byte-address and memory-address width.
REQ-003 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  SHALL be the asynchronous, active-high reset.
REQ-005 req_valid  in  1  SHALL flag that a memory request is presented.
REQ-006 req_ready  out  1  SHALL flag that the unit accepts a request this cycle.
REQ-007 req_we  in  1  SHALL select store (1) or load (0).
REQ-008 req_size  in  1  SHALL select byte (0) or halfword (1).
REQ-009 req_unsigned  in  1  SHALL select zero-extension (1) or sign-extension (0) on byte loads.
REQ-010 req_addr  in  ADDR_WIDTH  SHALL carry the byte address.
REQ-011 req_wdata  in  DATA_WIDTH  SHALL carry store data; bytes use [7:0].
REQ-012 resp_valid  out  1  SHALL pulse for one cycle at request completion.
REQ-013 resp_rdata  out  DATA_WIDTH  SHALL carry load data, valid while resp_valid=1.
REQ-014 resp_err  out  1  SHALL flag a misaligned request, valid while resp_valid=1.
REQ-015 mem_addr  out  ADDR_WIDTH  SHALL drive the word address to the data memory.
REQ-016 mem_data  out  DATA_WIDTH  SHALL drive the write word to the data memory.
REQ-017 mem_we  out  1  SHALL drive the data-memory write enable.
REQ-018 mem_q  in  DATA_WIDTH  SHALL receive the combinational memory read word for mem_addr in the same cycle.

Function
REQ-019 The FSM SHALL have the states IDLE, LOAD, RMW_READ, WRITE and RESP; req_ready SHALL be 1 only in IDLE with rst=0.
REQ-020 An accept SHALL be req_valid & req_ready at a rising edge; the unit SHALL latch we, size, unsigned, addr and wdata on accept.
REQ-021 Word address SHALL be {1'b0, addr[ADDR_WIDTH-1:1]}; mem_addr SHALL hold the latched word address in LOAD, RMW_READ and WRITE, and 0 otherwise.
REQ-022 Byte lanes SHALL be little-endian: addr[0]=0 selects [7:0] and addr[0]=1 selects [15:8].
REQ-023 Accept in IDLE SHALL transition as follows: halfword with addr[0]=1 -> RESP with err=1 and no memory access; load -> LOAD; halfword store -> WRITE; byte store -> RMW_READ.
REQ-024 LOAD SHALL register the extracted data from mem_q and then go to RESP.
REQ-025 For halfword loads, resp_rdata SHALL be the mem_q word; for byte loads, it SHALL be the selected byte, sign- or zero-extended to 16 bits.
REQ-026 RMW_READ SHALL register a merged word (mem_q with the selected byte replaced by wdata[7:0]) and then go to WRITE.
REQ-027 WRITE SHALL assert mem_we=1 for exactly one cycle, with mem_data set to the merged word (byte store) or wdata (halfword store), and then go to RESP.
REQ-028 mem_we SHALL be 0 in every state except WRITE, and mem_data SHALL be 0 outside WRITE.
REQ-029 RESP SHALL assert resp_valid=1 for one cycle and then return to IDLE.
REQ-030 resp_rdata SHALL be 0 for stores and errors.
REQ-031 Latency from the accept edge to resp_valid SHALL be: load 2 cycles, halfword store 2 cycles, byte store 3 cycles, misaligned 1 cycle.
REQ-032 Back-to-back operation SHALL allow a new accept in the cycle after RESP; requests presented outside IDLE SHALL be held off, not dropped.
REQ-033 Byte accesses SHALL never be misaligned; addresses SHALL wrap modulo 2^ADDR_WIDTH with no range checking.

Reset
REQ-034 While rst=1: state=IDLE, req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_addr=0, mem_data=0, and all latched registers=0.
REQ-035 Reset asserted mid-operation SHALL abandon the request immediately: mem_we SHALL drop asynchronously and no response SHALL be issued.
REQ-036 The first accept SHALL be possible at the first rising edge after rst deasserts.

Verification
REQ-037 Halfword store 0xBEEF to addr 0x0010, then halfword load of 0x0010 -> mem_we pulse with mem_addr=0x0008, mem_data=0xBEEF; load resp_rdata=0xBEEF two cycles after accept.
REQ-038 Memory word 0x0008 holds 0xBEEF; byte store 0x12 to addr 0x0011 -> RMW_READ then WRITE with mem_data=0x12EF; resp_valid three cycles after accept.
REQ-039 Word 0x0008 holds 0x80EF; byte load of addr 0x0011 with req_unsigned=0 -> resp_rdata=0xFF80; with req_unsigned=1 -> resp_rdata=0x0080.
REQ-040 Halfword load of addr 0x0003 -> resp_valid with resp_err=1 one cycle after accept, mem_we never asserted, resp_rdata=0.
REQ-041 rst asserted during WRITE of a byte store -> mem_we=0 within the same cycle, no resp_valid, req_ready=1 after release, and the next load completes normally.
REQ-042 req_valid held high across two queued loads -> second accept in the cycle after the first RESP, and req_ready=0 in LOAD and RESP.
